// File: rtl/pipe_pkg.sv
// pipe_pkg: shared depth limits, collapse-mode constants and stage popcount
package pipe_pkg;
   localparam int MAX_DEPTH = 8;
   localparam int OCC_W = 4;
   localparam bit COLLAPSE_OFF = 1'b0;
   localparam bit COLLAPSE_ON = 1'b1;
   function automatic logic [OCC_W-1:0] pop_count(input logic [MAX_DEPTH-1:0] v);
      logic [OCC_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_DEPTH; i++) n = n + OCC_W'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/pipe_cell.sv
// pipe_cell: one pipeline stage, valid+data register with load enable and valid clear
module pipe_cell #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clr,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   output logic             v_out,
   output logic [WIDTH-1:0] d_out
);
   logic             v_d, v_q;
   logic [WIDTH-1:0] data_d, data_q;
   always_comb begin
      v_d    = clr ? 1'b0 : load ? v_in : v_q;
      data_d = (load & v_in & ~clr) ? d_in : data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end
   assign v_out = v_q;
   assign d_out = data_q;
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: valid/ready register chain with optional bubble collapsing
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int WIDTH    = 18,
   parameter int DEPTH    = 2,
   parameter bit COLLAPSE = COLLAPSE_ON
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [OCC_W-1:0] occupancy
);
   if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, clk_en};
      assign q         = d;
      assign out_valid = in_valid;
      assign in_ready  = out_ready & ~flush;
      assign occupancy = '0;
   end else begin : g_chain
      logic [DEPTH:0]   v;
      logic [WIDTH-1:0] data [0:DEPTH];
      logic [DEPTH:1]   adv;
      logic             go, nxt;
      assign v[0]    = in_valid;
      assign data[0] = d;
      // Walk from the output end so each stage sees whether the one ahead moves
      always_comb begin
         go  = clk_en & ~flush;
         nxt = out_ready;
         adv = '0;
         for (int k = DEPTH; k >= 1; k--) begin
            adv[k] = COLLAPSE ? go & (~v[k] | nxt) : go & (out_ready | ~v[DEPTH]);
            nxt    = adv[k];
         end
      end
      for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
         pipe_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .load  (adv[k]),
            .clr   (flush),
            .v_in  (v[k-1]),
            .d_in  (data[k-1]),
            .v_out (v[k]),
            .d_out (data[k])
         );
      end
      assign q         = data[DEPTH];
      assign out_valid = v[DEPTH];
      assign in_ready  = adv[1];
      assign occupancy = pop_count(MAX_DEPTH'(v[DEPTH:1]));
   end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed vector table plus hand sequences for pipe_reg_chain
module tb_pipe_reg_chain;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, clk_en, flush, in_valid, out_ready;
   logic [17:0] d;
   logic a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
   logic [17:0] a_q, b_q, c_q;
   logic [3:0] a_occ, b_occ, c_occ;
   int n_vec = 0;
   int n_err = 0;
   pipe_reg_chain #(.WIDTH(18), .DEPTH(3), .COLLAPSE(1'b1)) u_a (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
      .d(d), .out_valid(a_ov), .out_ready(out_ready), .q(a_q), .occupancy(a_occ));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(3), .COLLAPSE(1'b0)) u_b (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
      .d(d), .out_valid(b_ov), .out_ready(out_ready), .q(b_q), .occupancy(b_occ));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(0), .COLLAPSE(1'b1)) u_c (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
      .d(d), .out_valid(c_ov), .out_ready(out_ready), .q(c_q), .occupancy(c_occ));
   typedef struct {
      logic        rst, en, fl, iv;
      logic [17:0] d;
      logic        ordy;
      logic        ov;
      logic [17:0] q;
      logic        ir;
      logic [3:0]  occ;
   } vec_t;
   vec_t tbl[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic e, input logic f, input logic iv,
                        input logic [17:0] dd, input logic o);
      rst = r; clk_en = e; flush = f; in_valid = iv; d = dd; out_ready = o;
   endtask
   initial begin
      // rst en fl iv d ordy | ov q ir occ  (expected before the edge, DEPTH=3 collapse)
      tbl.push_back('{0,1,0,1,18'h1,1,     0,18'h0,1,0});
      tbl.push_back('{0,1,0,1,18'h2,1,     0,18'h0,1,1});
      tbl.push_back('{0,1,0,1,18'h3,1,     0,18'h0,1,2});
      tbl.push_back('{0,1,0,1,18'h4,1,     1,18'h1,1,3});
      tbl.push_back('{0,1,0,1,18'h5,1,     1,18'h2,1,3});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h3,1,3});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h4,1,2});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h5,1,1});
      tbl.push_back('{0,1,0,0,18'h0,0,     0,18'h5,1,0});
      tbl.push_back('{0,1,0,1,18'h11,0,    0,18'h5,1,0});
      tbl.push_back('{0,1,0,1,18'h12,0,    0,18'h5,1,1});
      tbl.push_back('{0,1,0,1,18'h13,0,    0,18'h5,1,2});
      tbl.push_back('{0,1,0,1,18'h14,0,    1,18'h11,0,3});
      tbl.push_back('{0,1,0,1,18'h14,1,    1,18'h11,1,3});
      tbl.push_back('{0,1,0,0,18'h0,0,     1,18'h12,0,3});
      tbl.push_back('{0,0,1,1,18'h77,1,    1,18'h12,0,3});
      tbl.push_back('{0,1,0,0,18'h0,1,     0,18'h12,1,0});
      tbl.push_back('{0,1,0,1,18'h21,1,    0,18'h12,1,0});
      tbl.push_back('{0,0,0,1,18'h22,1,    0,18'h12,0,1});
      tbl.push_back('{0,1,0,1,18'h22,1,    0,18'h12,1,1});
      tbl.push_back('{0,0,0,1,18'h23,1,    0,18'h12,0,2});
      tbl.push_back('{0,1,0,1,18'h23,1,    0,18'h12,1,2});
      tbl.push_back('{0,0,0,0,18'h0,1,     1,18'h21,0,3});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h21,1,3});
      tbl.push_back('{0,0,0,0,18'h0,1,     1,18'h22,0,2});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h22,1,2});
      tbl.push_back('{0,1,0,0,18'h0,1,     1,18'h23,1,1});
      tbl.push_back('{0,1,0,1,18'h31,0,    0,18'h23,1,0});
      tbl.push_back('{0,1,0,1,18'h32,0,    0,18'h23,1,1});
      tbl.push_back('{1,1,0,1,18'h33,1,    0,18'h23,1,2});
      tbl.push_back('{0,1,0,0,18'h0,1,     0,18'h0,1,0});
      tbl.push_back('{0,1,0,0,18'h0,1,     0,18'h0,1,0});
      tbl.push_back('{0,1,0,1,18'h2AAAA,1, 0,18'h0,1,0});
      drive(1, 1, 0, 0, 18'h0, 0);
      @(negedge clk);
      @(negedge clk);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         #1;
         chk($sformatf("a_ov[%0d]", i), a_ov, tbl[i].ov);
         chk($sformatf("a_q[%0d]", i), a_q, tbl[i].q);
         chk($sformatf("a_ir[%0d]", i), a_ir, tbl[i].ir);
         chk($sformatf("a_occ[%0d]", i), a_occ, tbl[i].occ);
         chk($sformatf("c_q[%0d]", i), c_q, tbl[i].d);
         chk($sformatf("c_ov[%0d]", i), c_ov, tbl[i].iv);
         chk($sformatf("c_ir[%0d]", i), c_ir, tbl[i].ordy & ~tbl[i].fl);
         chk($sformatf("c_occ[%0d]", i), c_occ, 4'd0);
         @(negedge clk);
      end
      // Gapped items with a stalled sink: lockstep keeps the bubble, collapse packs it
      drive(1, 1, 0, 0, 18'h0, 0);
      @(negedge clk);
      drive(0, 1, 0, 1, 18'h41, 0);
      #1;
      chk("b_rst_ov", b_ov, 1'b0);
      chk("b_rst_q", b_q, 18'h0);
      chk("b_rst_ir", b_ir, 1'b1);
      @(negedge clk);
      drive(0, 1, 0, 0, 18'h0, 0);
      @(negedge clk);
      drive(0, 1, 0, 1, 18'h42, 0);
      @(negedge clk);
      drive(0, 1, 0, 0, 18'h0, 0);
      #1;
      chk("gap3_a_ir", a_ir, 1'b1);
      chk("gap3_a_occ", a_occ, 4'd2);
      chk("gap3_b_ir", b_ir, 1'b0);
      chk("gap3_b_occ", b_occ, 4'd2);
      chk("gap3_b_q", b_q, 18'h41);
      @(negedge clk);
      #1;
      chk("gap4_a_ir", a_ir, 1'b1);
      chk("gap4_a_q", a_q, 18'h41);
      chk("gap4_b_ir", b_ir, 1'b0);
      chk("gap4_b_occ", b_occ, 4'd2);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("gap5_a_ov", a_ov, 1'b1);
      chk("gap5_a_q", a_q, 18'h42);
      chk("gap5_b_ov", b_ov, 1'b0);
      chk("gap5_b_occ", b_occ, 4'd1);
      @(negedge clk);
      #1;
      chk("gap6_a_ov", a_ov, 1'b0);
      chk("gap6_a_occ", a_occ, 4'd0);
      chk("gap6_b_ov", b_ov, 1'b1);
      chk("gap6_b_q", b_q, 18'h42);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 18, SHALL be the data width in bits (1..48).
REQ-002 Parameter DEPTH, default 2, SHALL be the number of register stages (0..8); 0 means bypass.
REQ-003 Parameter COLLAPSE, default 1, SHALL select bubble-collapsing advance (1) or lockstep shift (0).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 clk_en  input  1  SHALL be the global stage enable; 0 freezes all state.
REQ-007 flush  input  1  SHALL be the synchronous invalidate of all stages.
REQ-008 in_valid  input  1  SHALL mark d as valid.
REQ-009 in_ready  output  1  SHALL indicate the chain accepts d this cycle.
REQ-010 d  input  WIDTH  SHALL be the input data.
REQ-011 out_valid  output  1  SHALL mark q as valid.
REQ-012 out_ready  input  1  SHALL indicate downstream accepts q this cycle.
REQ-013 q  output  WIDTH  SHALL be the output data (last stage).
REQ-014 occupancy  output  4  SHALL be the count of valid stages (0..DEPTH).

Function
REQ-015 Stage k (1..DEPTH) SHALL hold data[k] and valid v[k]; stage 0 is {d, in_valid}; stage DEPTH drives q/out_valid.
REQ-016 COLLAPSE=1: adv[k] = clk_en & ~flush & (~v[k] | adv[k+1]), with adv[DEPTH+1] = out_ready.
REQ-017 COLLAPSE=0: every adv[k] = clk_en & ~flush & (out_ready | ~v[DEPTH]); bubbles are preserved.
REQ-018 in_ready SHALL equal adv[1]; the out_ready-to-in_ready combinational path is permitted.
REQ-019 On adv[k], v[k] SHALL load v[k-1]; data[k] SHALL load data[k-1] only when v[k-1]=1, else hold.
REQ-020 Without adv[k], stage k SHALL hold data and valid.
REQ-021 A transfer SHALL occur on valid&ready at each end; a full chain with out_ready=1 and in_valid=1 SHALL accept and emit in the same cycle.
REQ-022 Latency SHALL be DEPTH cycles from input transfer to out_valid, with clk_en=1 and an empty chain (COLLAPSE=1).
REQ-023 Throughput SHALL be one item per cycle while out_ready=1 and clk_en=1.
REQ-024 flush=1 SHALL clear all v[k] on the next edge (data held), SHALL force in_ready=0, and SHALL take priority over clk_en.
REQ-025 clk_en=0 SHALL force in_ready=0 and hold all state; out_valid/q stay stable.
REQ-026 occupancy SHALL be registered-state derived (popcount of v) and update with v.
REQ-027 DEPTH=0: q=d, out_valid=in_valid, in_ready=out_ready & ~flush, occupancy=0; no registers inferred.
REQ-028 Item order SHALL be preserved; no item SHALL be dropped or duplicated except by flush/rst.

Reset
REQ-029 rst=1 SHALL on the next edge clear all v[k] and data[k] to 0, with priority over flush and clk_en.
REQ-030 After reset: out_valid=0, q=0, occupancy=0; in_ready follows REQ-016/017 (1 when clk_en=1, flush=0).
REQ-031 Reset mid-transfer SHALL discard all in-flight items; an input presented in the reset cycle SHALL NOT be captured.

Structure
REQ-032 Package pipe_pkg SHALL hold MAX_DEPTH=8, OCC_W=4 and the COLLAPSE mode constants.
REQ-033 One sub-module, pipe_cell (single stage: data+valid register with load enable, sync reset), SHALL be instantiated DEPTH times via generate.

Verification
REQ-034 WIDTH=18, DEPTH=3: rst, then d=0x00001..0x00005 back-to-back, out_ready=1 -> q=0x00001 with out_valid 3 cycles after first accept, then one per cycle, occupancy settles at 3.
REQ-035 DEPTH=3, COLLAPSE=1: out_ready=0, feed 4 items -> 3 accepted, in_ready=0, occupancy=3; raise out_ready -> 4th accepted the same cycle the 1st leaves.
REQ-036 DEPTH=3, COLLAPSE=0 vs 1: items at cycles 0 and 2, out_ready=0 after cycle 3 -> lockstep keeps the 1-cycle gap and stalls with occupancy=2; collapse packs them and in_ready stays 1.
REQ-037 Full chain, flush=1 one cycle with clk_en=0 -> next cycle out_valid=0, occupancy=0, q unchanged.
REQ-038 clk_en toggling 1,0,1,0 with steady stream -> each item delivered exactly once, in order, latency counted in enabled cycles only.
REQ-039 rst asserted with occupancy=2 and in_valid=1 -> next cycle q=0, out_valid=0, occupancy=0; the input in the reset cycle is never emitted; DEPTH=0 passes d=0x2AAAA to q combinationally.
